// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning front end: channel
// bit map and the per-channel debounce state type.
package btn_pkg;

    localparam int N_BTN = 5;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    typedef enum logic [1:0] {
        IDLE0,
        CHK1,
        HELD1,
        CHK0
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single button channel: synchroniser, debounce FSM and press strobe.
// Optional hold-to-repeat strobes when BTN_AUTOREPEAT_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    db_state_t      state, stateNext;
    logic [CW-1:0]  cnt, cntNext;
    logic           levelNext;
    logic           pulseNext;
    logic           pulseAll;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            level <= levelNext;
            pulse <= pulseAll;
        end
    end

    // Any reversal of s while checking drops the count back to zero.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        levelNext = level;
        pulseNext = 1'b0;
        case (state)
            IDLE0: begin
                if (s) begin
                    stateNext = CHK1;
                    cntNext   = CW'(1);
                end else begin
                    cntNext   = '0;
                end
            end
            CHK1: begin
                if (!s) begin
                    stateNext = IDLE0;
                    cntNext   = '0;
                end else if (cnt == CNT_TERM) begin
                    stateNext = HELD1;
                    cntNext   = '0;
                    levelNext = 1'b1;
                    pulseNext = 1'b1;
                end else begin
                    cntNext   = cnt + CW'(1);
                end
            end
            HELD1: begin
                if (!s) begin
                    stateNext = CHK0;
                    cntNext   = CW'(1);
                end
            end
            CHK0: begin
                if (s) begin
                    stateNext = HELD1;
                    cntNext   = '0;
                end else if (cnt == CNT_TERM) begin
                    stateNext = IDLE0;
                    cntNext   = '0;
                    levelNext = 1'b0;
                end else begin
                    cntNext   = cnt + CW'(1);
                end
            end
            default: begin
                stateNext = IDLE0;
                cntNext   = '0;
                levelNext = 1'b0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RCNT_TERM   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rcnt, rcntNext;
    logic          repeatHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcntNext;
        end
    end

    // Reloading to DELAY-PERIOD makes every later strobe land PERIOD apart.
    always_comb begin
        rcntNext  = '0;
        repeatHit = 1'b0;
        if (state == HELD1 && s) begin
            if (rcnt == RCNT_TERM) begin
                repeatHit = 1'b1;
                rcntNext  = RCNT_RELOAD;
            end else begin
                rcntNext  = rcnt + RW'(1);
            end
        end
    end

    assign pulseAll = pulseNext | repeatHit;
`else
    assign pulseAll = pulseNext;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw push-buttons into stable levels and press strobes.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat strobes on every channel.
module btn_conditioner #(
    parameter int N_BTN           = btn_pkg::N_BTN,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
        $error("btn_conditioner: invalid parameter set");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed button scenarios checked against a
// run-length debounce model; BTN_AUTOREPEAT_EN adds repeat expectations.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int SS = 2;
    localparam int DB = 8;
    localparam int RD = 16;
    localparam int RP = 4;

`ifdef BTN_AUTOREPEAT_EN
    localparam int PRESS_PULSES = 3;
    localparam int HOLD_PULSES  = 4;
`else
    localparam int PRESS_PULSES = 1;
    localparam int HOLD_PULSES  = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;

    int checks = 0;
    int failures = 0;
    int pulseCount[N_BTN];
    int base[N_BTN];

    logic [N_BTN-1:0] mLevel;
    logic [N_BTN-1:0] mPulse;
    logic [N_BTN-1:0] mHist[SS];
    int               mRun[N_BTN];
`ifdef BTN_AUTOREPEAT_EN
    int               mHold[N_BTN];
`endif

    btn_conditioner #(
        .N_BTN           (N_BTN),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Level flips once the delayed input has disagreed with it DB edges in a row.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mLevel <= '0;
            mPulse <= '0;
            for (int k = 0; k < SS; k++) mHist[k] <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                mRun[i] <= 0;
`ifdef BTN_AUTOREPEAT_EN
                mHold[i] <= 0;
`endif
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                mPulse[i] <= 1'b0;
                if (mHist[SS-1][i] != mLevel[i]) begin
`ifdef BTN_AUTOREPEAT_EN
                    mHold[i] <= 0;
`endif
                    if (mRun[i] + 1 >= DB) begin
                        mLevel[i] <= mHist[SS-1][i];
                        mPulse[i] <= mHist[SS-1][i];
                        mRun[i]   <= 0;
                    end else begin
                        mRun[i]   <= mRun[i] + 1;
                    end
                end else begin
                    mRun[i] <= 0;
`ifdef BTN_AUTOREPEAT_EN
                    if (mLevel[i]) begin
                        mHold[i] <= mHold[i] + 1;
                        if (mHold[i] + 1 >= RD && ((mHold[i] + 1 - RD) % RP) == 0)
                            mPulse[i] <= 1'b1;
                    end else begin
                        mHold[i] <= 0;
                    end
`endif
                end
            end
            mHist[0] <= btn_raw;
            for (int k = 1; k < SS; k++) mHist[k] <= mHist[k-1];
        end
    end

    task automatic checkOutput(input string name, input logic [N_BTN-1:0] act,
                               input logic [N_BTN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput("model_level", btn_level, mLevel);
        checkOutput("model_pulse", btn_pulse, mPulse);
        for (int i = 0; i < N_BTN; i++) pulseCount[i] += int'(btn_pulse[i]);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] v);
        btn_raw = v;
    endtask

    task automatic snapshot();
        for (int i = 0; i < N_BTN; i++) base[i] = pulseCount[i];
    endtask

    initial begin
        rst_n = 1'b0;
        btn_raw = '1;
        for (int i = 0; i < N_BTN; i++) begin
            pulseCount[i] = 0;
            base[i] = 0;
        end

        $display("[TB] reset with all buttons pressed");
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("reset_level", btn_level, 5'b00000);
            checkOutput("reset_pulse", btn_pulse, 5'b00000);
        end
        applyStimulus(5'b00000);
        rst_n = 1'b1;
        steps(4);
        checkCount("reset_no_pulse", pulseCount[BTN_C] + pulseCount[BTN_D], 0);

        $display("[TB] clean press on btnd");
        snapshot();
        applyStimulus(5'b10000);
        steps(9);
        checkOutput("press_edge8_level", btn_level, 5'b00000);
        step();
        checkOutput("press_edge9_level", btn_level, 5'b10000);
        checkOutput("press_edge9_pulse", btn_pulse, 5'b10000);
        step();
        checkOutput("press_edge10_pulse", btn_pulse, 5'b00000);
        steps(19);
        applyStimulus(5'b00000);
        steps(9);
        checkOutput("release_edge8_level", btn_level, 5'b10000);
        step();
        checkOutput("release_edge9_level", btn_level, 5'b00000);
        checkOutput("release_edge9_pulse", btn_pulse, 5'b00000);
        checkCount("press_pulses", pulseCount[BTN_D] - base[BTN_D], PRESS_PULSES);
        steps(3);

        $display("[TB] bouncing press on btnc");
        snapshot();
        applyStimulus(5'b00001);
        steps(5);
        applyStimulus(5'b00000);
        steps(2);
        applyStimulus(5'b00001);
        steps(9);
        checkOutput("bounce_edge8_level", btn_level, 5'b00000);
        step();
        checkOutput("bounce_edge9_level", btn_level, 5'b00001);
        checkOutput("bounce_edge9_pulse", btn_pulse, 5'b00001);
        steps(10);
        checkCount("bounce_pulses", pulseCount[BTN_C] - base[BTN_C], 1);
        applyStimulus(5'b00000);
        steps(12);
        checkOutput("bounce_released", btn_level, 5'b00000);

        $display("[TB] short glitch on btnl");
        snapshot();
        applyStimulus(5'b00010);
        steps(6);
        applyStimulus(5'b00000);
        steps(12);
        checkOutput("glitch_level", btn_level, 5'b00000);
        checkCount("glitch_pulses", pulseCount[BTN_L] - base[BTN_L], 0);

        $display("[TB] simultaneous press on btnu and btnr");
        snapshot();
        applyStimulus(5'b01100);
        steps(9);
        checkOutput("dual_edge8_level", btn_level, 5'b00000);
        step();
        checkOutput("dual_edge9_level", btn_level, 5'b01100);
        checkOutput("dual_edge9_pulse", btn_pulse, 5'b01100);
        steps(10);
        applyStimulus(5'b00000);
        steps(9);
        checkOutput("dual_rel_edge8_level", btn_level, 5'b01100);
        step();
        checkOutput("dual_rel_edge9_level", btn_level, 5'b00000);
        checkOutput("dual_rel_edge9_pulse", btn_pulse, 5'b00000);
        checkCount("dual_pulses_u", pulseCount[BTN_U] - base[BTN_U], 1);
        checkCount("dual_pulses_r", pulseCount[BTN_R] - base[BTN_R], 1);
        steps(3);

        $display("[TB] reset during qualification on btnd");
        snapshot();
        applyStimulus(5'b10000);
        steps(6);
        rst_n = 1'b0;
        steps(3);
        checkOutput("midreset_level", btn_level, 5'b00000);
        checkCount("midreset_pulses", pulseCount[BTN_D] - base[BTN_D], 0);
        rst_n = 1'b1;
        steps(9);
        checkOutput("after_reset_edge8_level", btn_level, 5'b00000);
        step();
        checkOutput("after_reset_edge9_level", btn_level, 5'b10000);
        checkOutput("after_reset_edge9_pulse", btn_pulse, 5'b10000);
        steps(24);
`ifdef BTN_AUTOREPEAT_EN
        checkOutput("repeat_edge33_pulse", btn_pulse, 5'b10000);
`endif
        checkCount("hold_pulses", pulseCount[BTN_D] - base[BTN_D], HOLD_PULSES);

        $display("[TB] asynchronous reset while level is high");
        checkOutput("pre_async_level", btn_level, 5'b10000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_level", btn_level, 5'b00000);
        checkOutput("async_pulse", btn_pulse, 5'b00000);
        applyStimulus(5'b00000);
        step();
        rst_n = 1'b1;
        steps(3);
        checkOutput("final_level", btn_level, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end input stage for the calculator: conditions the five raw push-buttons (btnc, btnl, btnu, btnr, btnd) before they reach the decoder/accumulator logic.
- Per button: synchroniser, debounce filter, and a one-cycle press pulse.
- The calculator consumes btn_level as the stable op-select level and btn_pulse as the single-shot accumulate/clear strobe.
- Stops one physical press from producing many accumulator updates.

Parameters:
- N_BTN, 5, number of button channels.
- SYNC_STAGES, 2, flip-flops in each synchroniser chain (min 2).
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must differ from btn_level before btn_level flips (10 ms at 100 MHz). Min 2.
- REPEAT_DELAY, 50000000, cycles of hold before the first repeat pulse. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 20000000, cycles between subsequent repeat pulses. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw pad inputs. Bit map: 0=btnc, 1=btnl, 2=btnu, 3=btnr, 4=btnd.
- btn_level  out  N_BTN  debounced button state.
- btn_pulse  out  N_BTN  one-cycle strobe on a debounced press.

Behaviour:
- Reset: rst_n low clears, asynchronously, all synchroniser flops, counters, btn_level and btn_pulse to 0. FSMs go to IDLE0.
- Channels are fully independent. Simultaneous activity on several bits is handled per channel with no priority and no interaction.
- Synchroniser: btn_raw[i] passes through SYNC_STAGES flops; the output is s[i]. Nothing else samples btn_raw.
- Per-channel FSM:
  - IDLE0 (level 0): if s=1, go to CHK1 with cnt=1; otherwise stay and hold cnt=0.
  - CHK1: if s=0, go to IDLE0 with cnt=0 (glitch rejected). Else if cnt==DEBOUNCE_CYCLES-1, go to HELD1, set level=1, assert pulse. Else cnt+1.
  - HELD1 (level 1): if s=0, go to CHK0 with cnt=1; otherwise stay.
  - CHK0: if s=1, go to HELD1 with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE0 with level=0 and no pulse. Else cnt+1.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps; it saturates by construction because the FSM leaves CHKx on the terminal count.
- Latency: the first clk edge that samples btn_raw=1 is edge 0. btn_level rises on edge SYNC_STAGES+DEBOUNCE_CYCLES-1 and btn_pulse is high for exactly the following cycle. Release uses the same latency.
- Bounce: any reversal of s during CHKx restarts qualification from zero. A press bouncing for less than DEBOUNCE_CYCLES still yields exactly one pulse.
- Held through reset: if btn_raw is 1 when rst_n deasserts, the press is qualified normally. One pulse follows after the full latency, counted from the first edge after rst_n release.
- Reset asserted mid-CHK: the count is discarded and no pulse is emitted.
- Outputs are registered; there are no combinational paths from btn_raw.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: in HELD1 a second counter rcnt runs.
  - An extra pulse is emitted when rcnt reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles while the channel stays in HELD1.
  - rcnt clears on leaving HELD1 or on reset.
  - Repeat pulses are one cycle wide.
- Undefined: exactly one btn_pulse per qualified press. REPEAT_* parameters are ignored and no rcnt logic exists.

Decomposition:
- Package btn_pkg:
  - Bit-index constants BTN_C=0, BTN_L=1, BTN_U=2, BTN_R=3, BTN_D=4, and N_BTN.
  - Enum db_state_t {IDLE0, CHK1, HELD1, CHK0}.
- Sub-module btn_debounce: a single channel (synchroniser, FSM, counter, optional repeat).
- btn_conditioner instantiates btn_debounce N_BTN times with a generate loop.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=8. Edge 0 is the first edge sampling the raw change.
1. Reset: hold rst_n=0 with btn_raw=5'b11111 for 5 cycles -> btn_level=0 and btn_pulse=0 throughout, including an rst_n drop mid-cycle (asynchronous clear).
2. Clean press: btn_raw[4]=1 held for 30 cycles -> btn_level[4] rises at edge 9, btn_pulse[4]=1 for one cycle only, other bits stay 0.
3. Bounce: btn_raw[0] high 5, low 2, then high 20 -> exactly one pulse; btn_level[0] rises 9 edges after the final rising sample.
4. Glitch reject: btn_raw[1] high for 6 cycles then low -> btn_level[1] and btn_pulse[1] never assert.
5. Release and simultaneous press: bits 2 and 3 rise together, then fall together after 20 cycles -> both pulse in the same cycle; both levels fall 9 edges after the release edge with no pulse.
6. Reset mid-count: btn_raw[4]=1, rst_n low at edge 5, released 3 cycles later with btn_raw still 1 -> no pulse before reset; one pulse follows a full 9-edge qualification after release.
   - With BTN_AUTOREPEAT_EN, REPEAT_DELAY=16 and REPEAT_PERIOD=4, a 40-cycle hold additionally produces repeat pulses 16, 20 and 24 cycles after btn_level rises.
